kernel_loader: RTL and testbench

Write-side driver for the convolution slice weight port. It accepts a serial kernel stream over a valid/ready handshake and writes each weight into successive MAC positions across one or more slices. It drives a shared `weight` bus and a one-hot `weight_valid` strobe, which is the exact format the slice captures. It flags when the full kernel has landed, so the image path may start.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/kernel_loader.sv | 102 ++++++++++
 tb/tb_kernel_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution slice and its weight loader.
package conv_pkg;

    localparam int unsigned WEIGHT_W  = 8;
    localparam int unsigned MAX_TOTAL = 64;

    typedef logic [MAX_TOTAL-1:0] onehot_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot vector with bit idx set; all-zero when idx falls outside width.
    function automatic onehot_t onehot(input int unsigned idx, input int unsigned width);
        onehot_t v;
        v = '0;
        if (idx < width && idx < MAX_TOTAL) begin
            v = onehot_t'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/kernel_loader.sv
// Streams a serial kernel into successive MAC weight slots over a shared bus
// with a one-hot write strobe, flagging completion and framing errors.
module kernel_loader
    import conv_pkg::*;
#(
    parameter int unsigned MAC_NB       = 3,
    parameter int unsigned SLICE_NB     = 1,
    parameter int unsigned WEIGHT_WIDTH = WEIGHT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WEIGHT_WIDTH-1:0]       kernel,
    input  logic                          kernel_valid,
    input  logic                          kernel_last,
    output logic                          kernel_ready,
    output logic [WEIGHT_WIDTH-1:0]       weight,
    output logic [MAC_NB*SLICE_NB-1:0]    weight_valid,
    output logic                          loaded,
    output logic                          error
);

    localparam int unsigned TOTAL = MAC_NB * SLICE_NB;
    localparam int unsigned IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [WEIGHT_WIDTH-1:0] weight_nxt;
    logic [TOTAL-1:0]        weight_valid_nxt;
    logic                    loaded_nxt;
    logic                    error_nxt;
    logic                    accept;

    // A start pulse always wins over a beat in the same cycle.
    assign kernel_ready = (state == LOAD) && !start;
    assign accept       = kernel_valid && kernel_ready;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            weight       <= '0;
            weight_valid <= '0;
            loaded       <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            weight       <= weight_nxt;
            weight_valid <= weight_valid_nxt;
            loaded       <= loaded_nxt;
            error        <= error_nxt;
        end
    end

    // Next-state, index and write-strobe generation.
    always_comb begin
        state_nxt        = state;
        idx_nxt          = idx;
        weight_nxt       = weight;
        weight_valid_nxt = '0;
        loaded_nxt       = 1'b0;
        error_nxt        = error;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                    error_nxt = 1'b0;
                end else begin
                    // Lags DONE entry by a cycle so the last strobe has been captured.
                    loaded_nxt = (state == DONE);
                end
            end
            LOAD: begin
                if (start) begin
                    idx_nxt   = '0;
                    error_nxt = 1'b0;
                end else if (accept) begin
                    weight_nxt       = kernel;
                    weight_valid_nxt = TOTAL'(onehot(32'(idx), TOTAL));
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                        if (!kernel_last) begin
                            error_nxt = 1'b1;
                        end
                    end else if (kernel_last) begin
                        state_nxt = IDLE;
                        error_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_kernel_loader.sv
// Self-checking bench for kernel_loader: directed scenarios plus randomized
// loads on a one-slice and a two-slice instance, checked against a kernel-level model.
module tb_kernel_loader;

    localparam int NU = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_i [NU];
    logic       kvalid  [NU];
    logic       klast   [NU];
    logic [7:0] kdata   [NU];
    logic       rdy     [NU];
    logic       ld      [NU];
    logic       er      [NU];
    logic [7:0] wt      [NU];
    logic [5:0] wvz     [NU];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NU; g++) begin : u
        localparam int T = 3 * (g + 1);

        logic [T-1:0] wv;
        logic [7:0]   w;
        logic         r, l, e;

        kernel_loader #(
            .MAC_NB(3),
            .SLICE_NB(32'(g + 1)),
            .WEIGHT_WIDTH(8)
        ) dut (
            .clk(clk),
            .rst(rst),
            .start(start_i[g]),
            .kernel(kdata[g]),
            .kernel_valid(kvalid[g]),
            .kernel_last(klast[g]),
            .kernel_ready(r),
            .weight(w),
            .weight_valid(wv),
            .loaded(l),
            .error(e)
        );

        assign rdy[g] = r;
        assign ld[g]  = l;
        assign er[g]  = e;
        assign wt[g]  = w;
        assign wvz[g] = 6'(wv);

        // Kernel-level model: how many weights have landed, and whether the kernel is complete.
        bit           loading, complete, m_err, m_loaded;
        int           n;
        logic [7:0]   m_w;
        logic [T-1:0] m_wv;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                loading = 0; complete = 0; m_err = 0; m_loaded = 0;
                n = 0; m_w = '0; m_wv = '0;
            end else begin
                m_loaded = complete && !start_i[g];
                m_wv = '0;
                if (start_i[g]) begin
                    loading = 1; complete = 0; n = 0; m_err = 0;
                end else if (loading && kvalid[g]) begin
                    m_w  = kdata[g];
                    m_wv = T'(1) << n;
                    if (n == T - 1) begin
                        loading = 0; complete = 1;
                        if (!klast[g]) m_err = 1;
                    end else if (klast[g]) begin
                        loading = 0; m_err = 1;
                    end else begin
                        n++;
                    end
                end
            end
        end

        always @(posedge clk) begin
            #1;
            if (!rst) begin
                chk($sformatf("u%0d weight", g), 32'(w), 32'(m_w));
                chk($sformatf("u%0d weight_valid", g), 32'(wv), 32'(m_wv));
                chk($sformatf("u%0d loaded", g), 32'(l), 32'(m_loaded));
                chk($sformatf("u%0d error", g), 32'(e), 32'(m_err));
                chk($sformatf("u%0d kernel_ready", g), 32'(r), 32'(loading && !start_i[g]));
                chk($sformatf("u%0d onehot0", g), 32'($onehot0(wv)), 32'(1));
            end
        end
    end

    task automatic pulse(input int k);
        @(negedge clk);
        start_i[k] = 1'b1;
        @(negedge clk);
        start_i[k] = 1'b0;
    endtask

    // Present one beat and return at the negedge after it is accepted.
    task automatic beat(input int k, input logic [7:0] d, input logic last);
        int n;
        n = 0;
        kvalid[k] = 1'b1;
        kdata[k]  = d;
        klast[k]  = last;
        #1;
        while (!rdy[k] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rdy[k]) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout u%0d: ready stayed %0d required 1", k, rdy[k]);
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NU; k++) begin
            start_i[k] = 0; kvalid[k] = 0; klast[k] = 0; kdata[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset weight", 32'(wt[0]), 32'(0));
        chk("reset weight_valid", 32'(wvz[0]), 32'(0));
        chk("reset loaded", 32'(ld[0]), 32'(0));
        chk("reset error", 32'(er[0]), 32'(0));
        chk("reset ready", 32'(rdy[0]), 32'(0));

        // Back-to-back weights
        pulse(0);
        beat(0, 8'd1, 1'b0); chk("b2b strobe0", 32'(wvz[0]), 32'h1);
        beat(0, 8'd1, 1'b0); chk("b2b strobe1", 32'(wvz[0]), 32'h2);
        beat(0, 8'd1, 1'b1); chk("b2b strobe2", 32'(wvz[0]), 32'h4);
        chk("b2b weight", 32'(wt[0]), 32'd1);
        kvalid[0] = 0;
        @(negedge clk);
        chk("b2b loaded", 32'(ld[0]), 32'd1);
        chk("b2b error", 32'(er[0]), 32'd0);

        // Bubbles between beats
        pulse(0);
        beat(0, 8'd5, 1'b0); chk("bub strobe0", 32'(wvz[0]), 32'h1);
        kvalid[0] = 0;
        repeat (2) begin @(negedge clk); chk("bub gap", 32'(wvz[0]), 32'h0); end
        beat(0, 8'd7, 1'b0); chk("bub strobe1", 32'(wvz[0]), 32'h2);
        kvalid[0] = 0;
        repeat (2) begin @(negedge clk); chk("bub gap", 32'(wvz[0]), 32'h0); end
        beat(0, 8'd9, 1'b1); chk("bub strobe2", 32'(wvz[0]), 32'h4);
        chk("bub weight", 32'(wt[0]), 32'd9);
        kvalid[0] = 0;
        @(negedge clk);

        // Early last
        pulse(0);
        beat(0, 8'd4, 1'b0); chk("early strobe0", 32'(wvz[0]), 32'h1);
        beat(0, 8'd8, 1'b1); chk("early strobe1", 32'(wvz[0]), 32'h2);
        chk("early error", 32'(er[0]), 32'd1);
        chk("early loaded", 32'(ld[0]), 32'd0);
        chk("early ready", 32'(rdy[0]), 32'd0);
        kvalid[0] = 0;
        @(negedge clk);

        // Missing last, then beats in DONE are ignored
        pulse(0);
        for (int b = 0; b < 3; b++) beat(0, 8'(b + 20), 1'b0);
        chk("miss error", 32'(er[0]), 32'd1);
        @(negedge clk);
        chk("miss loaded", 32'(ld[0]), 32'd1);
        repeat (3) begin
            #1;
            chk("done ready", 32'(rdy[0]), 32'd0);
            @(negedge clk);
            chk("done strobe", 32'(wvz[0]), 32'h0);
        end
        kvalid[0] = 0;

        // Restart after one beat with valid held
        pulse(0);
        beat(0, 8'd3, 1'b0);
        kdata[0] = 8'd6; klast[0] = 0; kvalid[0] = 1; start_i[0] = 1;
        #1;
        chk("restart ready", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        start_i[0] = 0;
        @(negedge clk);
        chk("restart strobe", 32'(wvz[0]), 32'h1);
        chk("restart weight", 32'(wt[0]), 32'd6);
        beat(0, 8'd7, 1'b0);
        beat(0, 8'd8, 1'b1);
        kvalid[0] = 0;
        @(negedge clk);

        // Two slices: strobes walk bits 0..5
        pulse(1);
        for (int k = 1; k <= 6; k++) begin
            beat(1, 8'(k), k == 6);
            chk("multi strobe", 32'(wvz[1]), 32'(1) << (k - 1));
            chk("multi weight", 32'(wt[1]), 32'(k));
        end
        kvalid[1] = 0;
        @(negedge clk);
        chk("multi loaded", 32'(ld[1]), 32'd1);

        // Asynchronous reset mid-load
        pulse(0);
        beat(0, 8'd11, 1'b0);
        beat(0, 8'd12, 1'b0);
        kdata[0] = 8'd13;
        #3;
        rst = 1'b1;
        #1;
        chk("arst weight", 32'(wt[0]), 32'd0);
        chk("arst strobe", 32'(wvz[0]), 32'h0);
        chk("arst ready", 32'(rdy[0]), 32'd0);
        chk("arst loaded", 32'(ld[1]), 32'd0);
        chk("arst error", 32'(er[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin @(negedge clk); chk("arst no strobe", 32'(wvz[0]), 32'h0); end
        kvalid[0] = 0;

        // Randomized loads with gaps, misplaced lasts and restarts
        for (int k = 0; k < NU; k++) begin
            for (int it = 0; it < 30; it++) begin
                int tgt, tt, gap;
                tt  = 3 * (k + 1);
                tgt = $urandom_range(0, tt);
                pulse(k);
                for (int b = 0; b < tt; b++) begin
                    gap = $urandom_range(0, 2);
                    kvalid[k] = 0;
                    klast[k]  = 1'($urandom);
                    repeat (gap) @(negedge clk);
                    if ($urandom_range(0, 15) == 0) pulse(k);
                    beat(k, 8'($urandom), b == tgt);
                    if (b == tgt) break;
                end
                kvalid[k] = 1'($urandom);
                repeat ($urandom_range(1, 3)) @(negedge clk);
                kvalid[k] = 0;
            end
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
